// File: rtl/adc_sar_ctrl.sv
// adc_sar_ctrl: 4-bit SAR conversion sequencer for a temperature-sensor ADC.
// Define ADC_ALARM_EN to build the over-temperature hysteresis alarm; otherwise o_alarm is tied low.
module adc_sar_ctrl #(
    parameter int SAMPLE_CYCLES = 2,
    parameter int ALARM_HI      = 12,
    parameter int ALARM_LO      = 8
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_cont,
    input  logic       i_comp,
    output logic       o_sample,
    output logic [3:0] o_dac,
    output logic [3:0] o_ADCout,
    output logic       o_valid,
    output logic       o_busy,
    output logic       o_alarm
);
    typedef enum logic [1:0] {IDLE, SAMPLE, CONV, DONE} state_t;
    localparam logic [3:0] SC = 4'(SAMPLE_CYCLES);
    if (SAMPLE_CYCLES < 1 || SAMPLE_CYCLES > 15 || ALARM_HI > 15 || ALARM_LO >= ALARM_HI) begin : g_bad_cfg
        $error("adc_sar_ctrl: illegal parameter set");
    end
    state_t     state_q;
    logic [3:0] cnt_q;
    logic [1:0] bit_q;
    logic [3:0] mask;
    logic [3:0] keep_d;
    assign mask   = 4'b0001 << bit_q;
    assign keep_d = i_comp ? o_dac : (o_dac & ~mask);
`ifdef ADC_ALARM_EN
    localparam logic [3:0] AHI = 4'(ALARM_HI);
    localparam logic [3:0] ALO = 4'(ALARM_LO);
`else
    assign o_alarm = 1'b0;
`endif
    // SAMPLE spans SAMPLE_CYCLES acquisition cycles plus one hold cycle before the first trial
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= 2'd3;
            o_sample <= 1'b0;
            o_dac    <= '0;
            o_ADCout <= '0;
            o_valid  <= 1'b0;
            o_busy   <= 1'b0;
`ifdef ADC_ALARM_EN
            o_alarm  <= 1'b0;
`endif
        end else begin
            o_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (i_start || i_cont) begin
                        state_q  <= SAMPLE;
                        cnt_q    <= '0;
                        o_sample <= 1'b1;
                        o_busy   <= 1'b1;
                    end
                end
                SAMPLE: begin
                    cnt_q    <= cnt_q + 4'd1;
                    o_sample <= (cnt_q + 4'd1) < SC;
                    if (cnt_q == SC) begin
                        state_q  <= CONV;
                        bit_q    <= 2'd3;
                        o_sample <= 1'b0;
                        o_dac    <= 4'b1000;
                    end
                end
                CONV: begin
                    if (bit_q == 2'd0) begin
                        state_q  <= DONE;
                        o_dac    <= '0;
                        o_ADCout <= keep_d;
                        o_valid  <= 1'b1;
`ifdef ADC_ALARM_EN
                        if (keep_d > AHI) o_alarm <= 1'b1;
                        else if (keep_d < ALO) o_alarm <= 1'b0;
`endif
                    end else begin
                        bit_q <= bit_q - 2'd1;
                        o_dac <= keep_d | (mask >> 1);
                    end
                end
                DONE: begin
                    bit_q <= 2'd3;
                    cnt_q <= '0;
                    if (i_cont) begin
                        state_q  <= SAMPLE;
                        o_sample <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        o_busy  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_sar_ctrl.sv
// tb_adc_sar_ctrl: randomized self-checking bench for adc_sar_ctrl against a binary-search reference model.
module tb_adc_sar_ctrl;
    localparam int S = 2;
    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_start = 1'b0;
    logic       i_cont = 1'b0;
    logic       i_comp;
    logic       o_sample;
    logic [3:0] o_dac;
    logic [3:0] o_ADCout;
    logic       o_valid;
    logic       o_busy;
    logic       o_alarm;
    int         level = 0;
    int         n_chk = 0;
    int         n_pass = 0;
    int         alarm_m = 0;

    adc_sar_ctrl #(.SAMPLE_CYCLES(S), .ALARM_HI(12), .ALARM_LO(8)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_cont(i_cont), .i_comp(i_comp),
        .o_sample(o_sample), .o_dac(o_dac), .o_ADCout(o_ADCout), .o_valid(o_valid),
        .o_busy(o_busy), .o_alarm(o_alarm)
    );

    always #5 i_clk = ~i_clk;
    assign i_comp = (level >= int'(o_dac));

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // Successive-approximation search: each trial is the kept prefix plus the next lower power of two
    function automatic logic [15:0] sar_trials(input int lvl);
        int lo = 0;
        int t;
        logic [15:0] r = '0;
        for (int b = 3; b >= 0; b--) begin
            t = lo + (1 << b);
            r = {r[11:0], 4'(t)};
            if (lvl >= t) lo = t;
        end
        return r;
    endfunction

    function automatic int alarm_next(input int a, input int lvl);
`ifdef ADC_ALARM_EN
        return lvl > 12 ? 1 : (lvl < 8 ? 0 : a);
`else
        return (lvl > 99) ? a : 0;
`endif
    endfunction

    task automatic run_single(input int lvl, input bit poke);
        int k = 0;
        int vk = -1;
        int nsamp = 0;
        int nv = 0;
        int busy_seen = 0;
        int dq[$];
        logic [15:0] g = '0;
        level = lvl;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        while (k < 20 && vk < 0) begin
            if (o_sample) nsamp++;
            if (o_dac != 0) dq.push_back(int'(o_dac));
            if (o_valid) vk = k;
            i_start = (poke && k == 4);
            if (vk < 0) begin
                tick();
                k++;
            end
        end
        i_start = 1'b0;
        alarm_m = alarm_next(alarm_m, lvl);
        check("latency", vk, S + 5);
        check("code", int'(o_ADCout), lvl);
        check("sample_len", nsamp, S);
        check("trial_count", dq.size(), 4);
        foreach (dq[i]) g = {g[11:0], 4'(dq[i])};
        check("trials", int'(g), int'(sar_trials(lvl)));
        check("alarm", int'(o_alarm), alarm_m);
        tick();
        check("valid_pulse", int'(o_valid), 0);
        for (int j = 0; j < 12; j++) begin
            tick();
            if (o_valid) nv++;
            if (o_busy) busy_seen = j;
        end
        check("no_extra_conv", nv, 0);
        check("idle_busy", int'(o_busy), 0);
        check("code_hold", int'(o_ADCout), lvl);
    endtask

    task automatic run_cont(input int lvl);
        int k = 0;
        int t;
        int j = 0;
        int nv = 0;
        int last = -1;
        int tq[$];
        level = lvl;
        i_cont = 1'b1;
        tick();
        while (k < 60 && tq.size() < 3) begin
            if (o_valid) begin
                tq.push_back(k);
                check("cont_code", int'(o_ADCout), lvl);
            end
            if (tq.size() < 3) begin
                tick();
                k++;
            end
        end
        check("cont_pulses", tq.size(), 3);
        if (tq.size() == 3) begin
            check("cont_first", tq[0], S + 5);
            check("cont_gap1", tq[1] - tq[0], S + 6);
            check("cont_gap2", tq[2] - tq[1], S + 6);
        end
        t = k;
        repeat (5) begin
            tick();
            k++;
        end
        i_cont = 1'b0;
        while (o_busy && j < 30) begin
            tick();
            k++;
            j++;
            if (o_valid) begin
                nv++;
                last = k;
            end
        end
        alarm_m = alarm_next(alarm_m, lvl);
        check("drop_pulses", nv, 1);
        check("drop_gap", last - t, S + 6);
        check("drop_busy", int'(o_busy), 0);
        check("drop_code", int'(o_ADCout), lvl);
        check("cont_alarm", int'(o_alarm), alarm_m);
    endtask

    initial begin
        int lvl;
        int nv = 0;
        int nb = 0;
        logic [15:0] tr;
        tick();
        tick();
        check("rst_sample", int'(o_sample), 0);
        check("rst_dac", int'(o_dac), 0);
        check("rst_code", int'(o_ADCout), 0);
        check("rst_valid", int'(o_valid), 0);
        check("rst_busy", int'(o_busy), 0);
        check("rst_alarm", int'(o_alarm), 0);
        i_rst = 1'b0;
        tick();
        run_single(11, 1'b0);
        run_single(0, 1'b0);
        run_single(15, 1'b0);
        run_single(11, 1'b1);
        run_single(13, 1'b0);
        run_single(10, 1'b0);
        run_single(7, 1'b0);
        for (int i = 0; i < 6; i++) run_single(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        run_cont(5);
        run_cont(int'($urandom_range(0, 15)));
        lvl = int'($urandom_range(0, 15));
        tr = sar_trials(lvl);
        level = lvl;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (4) tick();
        check("abort_bit2_dac", int'(o_dac), int'(tr[11:8]));
        i_rst = 1'b1;
        i_start = 1'b1;
        tick();
        alarm_m = 0;
        check("abort_busy", int'(o_busy), 0);
        check("abort_dac", int'(o_dac), 0);
        check("abort_sample", int'(o_sample), 0);
        check("abort_valid", int'(o_valid), 0);
        check("abort_code", int'(o_ADCout), 0);
        check("abort_alarm", int'(o_alarm), alarm_m);
        i_rst = 1'b0;
        i_start = 1'b0;
        for (int j = 0; j < 15; j++) begin
            tick();
            if (o_valid) nv++;
            if (o_busy) nb++;
        end
        check("abort_no_valid", nv, 0);
        check("abort_no_start", nb, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/adc_sar_ctrl.md
ADC_SAR_CTRL -- requirements
Module: adc_sar_ctrl

Interface
REQ-001 Parameter SAMPLE_CYCLES, default 2, cycles o_sample is held high per conversion; legal range 1..15.
REQ-002 Parameter ALARM_HI, default 12, 4-bit over-temperature set threshold.
REQ-003 Parameter ALARM_LO, default 8, 4-bit over-temperature clear threshold; ALARM_LO < ALARM_HI.
REQ-004 i_clk  input  1  main clock (500 MHz); all logic on rising edge.
REQ-005 i_rst  input  1  reset, synchronous, active-high.
REQ-006 i_start  input  1  single-conversion request, sampled each edge.
REQ-007 i_cont  input  1  continuous mode; when high, a new conversion starts after each one completes.
REQ-008 i_comp  input  1  comparator result; 1 = sensor voltage >= DAC level; settled within the cycle o_dac is driven.
REQ-009 o_sample  output  1  sample-switch enable to the temperature-sensor S/H.
REQ-010 o_dac  output  4  trial code to the capacitive DAC.
REQ-011 o_ADCout  output  4  last completed result; feeds the backend filter input.
REQ-012 o_valid  output  1  one-cycle pulse when o_ADCout updates.
REQ-013 o_busy  output  1  high in any state other than IDLE.
REQ-014 o_alarm  output  1  over-temperature flag (see Configuration).

Function
REQ-015 FSM states SHALL be IDLE, SAMPLE, CONV, DONE; all outputs registered.
REQ-016 IDLE -> SAMPLE when i_start=1 or i_cont=1; otherwise stay in IDLE.
REQ-017 SAMPLE: o_sample=1 for exactly SAMPLE_CYCLES cycles, o_dac=0; then -> CONV with bit index 3.
REQ-018 CONV: one cycle per bit, MSB first (bits 3,2,1,0); o_dac = accumulated result with the current bit set.
REQ-019 At the end of each CONV cycle, the current bit is kept if i_comp=1 and cleared if i_comp=0; after bit 0 -> DONE.
REQ-020 DONE: o_ADCout <= final 4-bit code; o_valid=1 for this cycle only; then -> SAMPLE if i_cont=1, else IDLE.
REQ-021 Latency: o_valid SHALL be high exactly SAMPLE_CYCLES+5 cycles after the edge that captured i_start (7 with the default).
REQ-022 i_start while o_busy=1 SHALL be ignored and not queued.
REQ-023 i_cont deasserted mid-conversion: the current conversion completes, then -> IDLE.
REQ-024 o_ADCout SHALL hold its value between o_valid pulses; code 0 and code 15 are reachable with no wrap-around.
REQ-025 Back-to-back continuous conversions SHALL have o_valid pulses spaced SAMPLE_CYCLES+6 cycles apart.

Reset
REQ-026 i_rst=1 at a clock edge SHALL force IDLE and set o_sample=0, o_dac=0, o_ADCout=0, o_valid=0, o_busy=0, o_alarm=0, bit index=3, and clear all counters.
REQ-027 Reset mid-conversion SHALL abort the conversion with no o_valid pulse; i_start is ignored on reset cycles.

Configuration
REQ-028 Macro ADC_ALARM_EN defined: o_alarm is registered. It sets on DONE when the result > ALARM_HI, clears on DONE when the result < ALARM_LO, and otherwise holds (hysteresis).
REQ-029 Macro ADC_ALARM_EN undefined: o_alarm is constant 0, no alarm logic is instantiated, and the port is still present.

Verification
REQ-030 Comparator model i_comp=(11>=o_dac), pulse i_start -> o_dac sequence 8,12,10,11; o_ADCout=4'b1011; o_valid high 7 cycles after start.
REQ-031 Sensor level 0 -> o_ADCout=0; sensor level 15 -> o_ADCout=15; o_sample high exactly 2 cycles in each case.
REQ-032 i_cont=1 with level 5 -> o_valid pulses every 8 cycles with o_ADCout=5; drop i_cont mid-CONV -> one more pulse, then o_busy=0.
REQ-033 i_start pulsed during CONV -> no extra conversion; assert i_rst during bit 2 -> next cycle IDLE, all outputs 0, no o_valid pulse.
REQ-034 With ADC_ALARM_EN, levels 13,10,7 in sequence -> o_alarm 1,1,0; without the macro, o_alarm stays 0 throughout.
